// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 decoder: select codes and the one-hot
// output type passed between the decode logic and the output stage.
package decoder_pkg;

    localparam logic [1:0] SEL_Y0 = 2'b00;
    localparam logic [1:0] SEL_Y1 = 2'b01;
    localparam logic [1:0] SEL_Y2 = 2'b10;
    localparam logic [1:0] SEL_Y3 = 2'b11;

    typedef logic [3:0] onehot4_t;

    localparam onehot4_t ONEHOT_NONE = 4'b0000;

endpackage : decoder_pkg

// File: rtl/decoder_2to4_comb.sv
// Pure combinational 2-to-4 decode with active-high enable.
// Bit n of y_o is set when e_i is high and {a_i,b_i} equals n.
module decoder_2to4_comb
    import decoder_pkg::*;
(
    input  logic     e_i,
    input  logic     a_i,
    input  logic     b_i,
    output onehot4_t y_o
);

    logic [1:0] sel_s;

    assign sel_s = {a_i, b_i};

    // Expand the select to a single strobe; disabled means no strobe at all.
    always_comb begin
        y_o = ONEHOT_NONE;
        if (e_i) begin
            case (sel_s)
                SEL_Y0:  y_o = 4'b0001;
                SEL_Y1:  y_o = 4'b0010;
                SEL_Y2:  y_o = 4'b0100;
                SEL_Y3:  y_o = 4'b1000;
                default: y_o = ONEHOT_NONE;
            endcase
        end else begin
            y_o = ONEHOT_NONE;
        end
    end

endmodule : decoder_2to4_comb

// File: rtl/decoder_2to4_with_enable.sv
// 2-to-4 line decoder with enable. With OUT_REG=1 the one-hot result is
// registered (one cycle of latency, synchronous active-low reset) so there
// is no combinational path from e/a/b to y0..y3. With OUT_REG=0 the decode
// drives the outputs directly and clk/rst_n are not used.
module decoder_2to4_with_enable
    import decoder_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic e,
    input  logic a,
    input  logic b,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3
);

    onehot4_t dec_s;
    onehot4_t out_s;

    decoder_2to4_comb u_decode (
        .e_i (e),
        .a_i (a),
        .b_i (b),
        .y_o (dec_s)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            onehot4_t y_d;
            onehot4_t y_q;

            // Next state is simply the current decode; no hold or history.
            always_comb begin
                y_d = dec_s;
            end

            // Output register; reset clears all strobes and wins over inputs.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    y_q <= ONEHOT_NONE;
                end else begin
                    y_q <= y_d;
                end
            end

            assign out_s = y_q;
        end else begin : g_out_comb
            assign out_s = dec_s;
        end
    endgenerate

    assign y0 = out_s[0];
    assign y1 = out_s[1];
    assign y2 = out_s[2];
    assign y3 = out_s[3];

endmodule : decoder_2to4_with_enable

// File: tb/tb_decoder_2to4_with_enable.sv
// Self-checking bench for decoder_2to4_with_enable (OUT_REG=1).
// Expected outputs are pushed to a scoreboard queue when inputs are driven
// and popped/compared one edge later when the registered output appears.
module tb_decoder_2to4_with_enable;

    logic clk;
    logic rst_n;
    logic e;
    logic a;
    logic b;
    logic y0;
    logic y1;
    logic y2;
    logic y3;

    int checks_r;
    int errors_r;

    logic [3:0] exp_q[$];
    logic [3:0] last_exp_r;

    decoder_2to4_with_enable #(.OUT_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .a     (a),
        .b     (b),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2),
        .y3    (y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written as a shift, independent of the RTL case table.
    function automatic logic [3:0] ref_decode(input logic en, input logic sa, input logic sb);
        logic [3:0] one;
        one = 4'b0001;
        if (en) begin
            return one << {sa, sb};
        end else begin
            return 4'b0000;
        end
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, then compare the output that edge produces.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic sa, input logic sb);
        logic [3:0] exp_v;
        logic [3:0] obs_v;
        logic [3:0] pop_cnt;
        @(negedge clk);
        rst_n = r;
        e     = en;
        a     = sa;
        b     = sb;
        if (r) begin
            exp_q.push_back(ref_decode(en, sa, sb));
        end else begin
            exp_q.push_back(4'b0000);
        end
        @(posedge clk);
        #1;
        obs_v = {y3, y2, y1, y0};
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 4'b0001, 4'b0000);
        end else begin
            exp_v = exp_q.pop_front();
            last_exp_r = exp_v;
            check(tag, obs_v, exp_v);
            // One-hot invariant: at most one strobe, exactly one iff enabled.
            pop_cnt = 4'($countones(obs_v));
            check({tag, "_onehot"}, pop_cnt, (r && en) ? 4'd1 : 4'd0);
        end
    endtask

    initial begin
        checks_r   = 0;
        errors_r   = 0;
        last_exp_r = 4'b0000;
        rst_n = 1'b0;
        e     = 1'b1;
        a     = 1'b1;
        b     = 1'b1;

        // Reset held two edges with inputs that would otherwise select y3.
        step("rst0", 1'b0, 1'b1, 1'b1, 1'b1);
        step("rst1", 1'b0, 1'b1, 1'b1, 1'b1);
        step("rel",  1'b1, 1'b1, 1'b1, 1'b1);

        // Reset and input changes between edges must not touch the outputs.
        @(negedge clk);
        rst_n = 1'b0;
        e     = 1'b1;
        a     = 1'b0;
        b     = 1'b0;
        #2;
        check("hold_mid", {y3, y2, y1, y0}, last_exp_r);
        rst_n = 1'b1;
        e     = 1'b1;
        a     = 1'b1;
        b     = 1'b1;

        // Enabled sweep.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            step("en_sweep", 1'b1, 1'b1, s[1], s[0]);
        end

        // Disabled sweep.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            step("dis_sweep", 1'b1, 1'b0, s[1], s[0]);
        end

        // Enable toggling with select fixed at 2.
        step("en_tog1", 1'b1, 1'b1, 1'b1, 1'b0);
        step("en_tog0", 1'b1, 1'b0, 1'b1, 1'b0);
        step("en_tog1b", 1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-operation reset for one edge, then recovery.
        step("mid_y1",   1'b1, 1'b1, 1'b0, 1'b1);
        step("mid_rst",  1'b0, 1'b1, 1'b0, 1'b1);
        step("mid_rec",  1'b1, 1'b1, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'b1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule : tb_decoder_2to4_with_enable
